// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared constants for the keypad front end of the step sequencer.
//   - Default key counts and filter lengths used by key_event_encoder.
//   - Fixed indices of the latch keys within the latch bank.
//   - Helper to size the debounce counter.
// -----------------------------------------------------------------------------
package keypad_pkg;

   // Default geometry of the keypad
   localparam int N_STEP_DEF      = 8;
   localparam int N_LATCH_DEF     = 2;
   localparam int DB_CYCLES_DEF   = 4;
   localparam int SYNC_STAGES_DEF = 2;

   // Latch key indices (bit positions in keys[N_LATCH-1:0] / latch_state)
   localparam int KEY_PLAY   = 0;
   localparam int KEY_SEQ_ON = 1;

   // Width needed to hold counts 0..db_cycles (at least one bit)
   function automatic int db_cnt_width(input int db_cycles);
      int w;
      w = $clog2(db_cycles + 1);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage : keypad_pkg

// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
// One raw push-button in, one debounced level and a press strobe out.
//   clk       in   system clock
//   n_rst     in   asynchronous active-low reset
//   key_raw   in   raw asynchronous key level, 1 = pressed
//   en        in   debounce sample strobe; the filter only advances when 1
//   key_down  out  debounced key level
//   rise      out  high for the single cycle after key_down goes 0 -> 1
// -----------------------------------------------------------------------------
module key_debouncer
   import keypad_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
   input  logic clk,
   input  logic n_rst,
   input  logic key_raw,
   input  logic en,
   output logic key_down,
   output logic rise
);

   localparam int                CNT_W    = db_cnt_width(DB_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic                   key_down_q;
   logic                   key_down_d;
   logic                   prev_q;
   logic                   prev_d;
   logic                   s;

   always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], key_raw};
      s          = sync_q[SYNC_STAGES-1];
      cnt_d      = cnt_q;
      key_down_d = key_down_q;
      prev_d     = key_down_q;

      // The counter measures how many consecutive enabled samples have
      // disagreed with the current debounced level. Any agreeing sample
      // restarts the count, so short glitches are discarded. The flip
      // happens on the sample that would take the count to DB_CYCLES,
      // which keeps the counter within 0..DB_CYCLES-1.
      if (en) begin
         if (s == key_down_q) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            key_down_d = ~key_down_q;
            cnt_d      = '0;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync_q     <= '0;
         cnt_q      <= '0;
         key_down_q <= 1'b0;
         prev_q     <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         cnt_q      <= cnt_d;
         key_down_q <= key_down_d;
         prev_q     <= prev_d;
      end
   end

   assign key_down = key_down_q;
   assign rise     = key_down_q & ~prev_q;

endmodule : key_debouncer

// File: rtl/key_event_encoder.sv
// -----------------------------------------------------------------------------
// key_event_encoder
// Keypad front end for the step sequencer: synchronises, debounces and
// edge-detects a bank of push buttons, turning step keys into one-cycle
// toggle pulses and latch keys into persistent toggled state bits.
//   clk          in   system clock
//   n_rst        in   asynchronous active-low reset
//   keys         in   raw key levels; [N_KEYS-1:N_LATCH] step keys,
//                     [N_LATCH-1:0] latch keys (KEY_PLAY, KEY_SEQ_ON, ...)
//   en           in   debounce sample strobe
//   clear_latch  in   synchronous clear of every latch_state bit
//   step_pulse   out  one-cycle press pulse, bit i <- keys[N_LATCH+i]
//   latch_state  out  toggled persistent state, bit j <- keys[j]
//   key_down     out  debounced key levels
//   any_pulse    out  OR of step_pulse
// -----------------------------------------------------------------------------
module key_event_encoder
   import keypad_pkg::*;
#(
   parameter int N_STEP      = N_STEP_DEF,
   parameter int N_LATCH     = N_LATCH_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
   input  logic                        clk,
   input  logic                        n_rst,
   input  logic [N_STEP+N_LATCH-1:0]   keys,
   input  logic                        en,
   input  logic                        clear_latch,
   output logic [N_STEP-1:0]           step_pulse,
   output logic [N_LATCH-1:0]          latch_state,
   output logic [N_STEP+N_LATCH-1:0]   key_down,
   output logic                        any_pulse
);

   localparam int N_KEYS = N_STEP + N_LATCH;

   // Parameter sanity checks, evaluated at elaboration
   if (N_STEP < 1) begin : g_bad_n_step
      $error("key_event_encoder: N_STEP must be >= 1");
   end
   if (N_LATCH < 1) begin : g_bad_n_latch
      $error("key_event_encoder: N_LATCH must be >= 1");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("key_event_encoder: SYNC_STAGES must be >= 2");
   end
   if (DB_CYCLES < 1) begin : g_bad_db
      $error("key_event_encoder: DB_CYCLES must be >= 1");
   end

   logic [N_KEYS-1:0]  rise;
   logic [N_KEYS-1:0]  key_down_w;
   logic [N_LATCH-1:0] latch_state_q;
   logic [N_LATCH-1:0] latch_state_d;

   // One independent filter per key; keys never interact
   for (genvar k = 0; k < N_KEYS; k++) begin : g_key
      key_debouncer #(
         .SYNC_STAGES (SYNC_STAGES),
         .DB_CYCLES   (DB_CYCLES)
      ) u_db (
         .clk      (clk),
         .n_rst    (n_rst),
         .key_raw  (keys[k]),
         .en       (en),
         .key_down (key_down_w[k]),
         .rise     (rise[k])
      );
   end

   // Latch keys invert their state on the edge where their rise strobe is
   // high. A clear on the same edge wins over the toggle.
   always_comb begin
      latch_state_d = latch_state_q ^ rise[N_LATCH-1:0];
      if (clear_latch) begin
         latch_state_d = '0;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         latch_state_q <= '0;
      end else begin
         latch_state_q <= latch_state_d;
      end
   end

   assign step_pulse  = rise[N_KEYS-1:N_LATCH];
   assign any_pulse   = |rise[N_KEYS-1:N_LATCH];
   assign latch_state = latch_state_q;
   assign key_down    = key_down_w;

endmodule : key_event_encoder

// File: tb/tb_key_event_encoder.sv
module tb_key_event_encoder;

   logic        clk;
   logic        n_rst;
   logic        en;
   logic        clear_latch;

   logic [9:0]  keys;
   logic [7:0]  step_pulse;
   logic [1:0]  latch_state;
   logic [9:0]  key_down;
   logic        any_pulse;

   logic [18:0] keys2;
   logic [15:0] step_pulse2;
   logic [2:0]  latch_state2;
   logic [18:0] key_down2;
   logic        any_pulse2;

   int checks;
   int errors;

   key_event_encoder dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .keys        (keys),
      .en          (en),
      .clear_latch (clear_latch),
      .step_pulse  (step_pulse),
      .latch_state (latch_state),
      .key_down    (key_down),
      .any_pulse   (any_pulse)
   );

   key_event_encoder #(
      .N_STEP      (16),
      .N_LATCH     (3),
      .SYNC_STAGES (2),
      .DB_CYCLES   (4)
   ) dut2 (
      .clk         (clk),
      .n_rst       (n_rst),
      .keys        (keys2),
      .en          (en),
      .clear_latch (clear_latch),
      .step_pulse  (step_pulse2),
      .latch_state (latch_state2),
      .key_down    (key_down2),
      .any_pulse   (any_pulse2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one posedge and return at the following negedge for sampling
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      keys = '1;
      en = 1'b1;
      clear_latch = 1'b0;
      n_rst = 1'b0;
      idle(3);
      checks++;
      if ({step_pulse, latch_state, key_down, any_pulse} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got step=%h latch=%b kd=%h any=%b required all 0",
                  step_pulse, latch_state, key_down, any_pulse);
      end
      n_rst = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         tick();
         if (c < 6) begin
            checks++;
            if (step_pulse !== 8'h00) begin
               errors++;
               $display("FAIL reset_early_pulse E%0d: got %h required 00", c, step_pulse);
            end
         end else if (c == 6) begin
            checks++;
            if (step_pulse !== 8'hFF || any_pulse !== 1'b1 || latch_state !== 2'b00) begin
               errors++;
               $display("FAIL reset_held_pulse E6: got step=%h any=%b latch=%b required FF 1 00",
                        step_pulse, any_pulse, latch_state);
            end
         end else begin
            checks++;
            if (step_pulse !== 8'h00 || latch_state !== 2'b11) begin
               errors++;
               $display("FAIL reset_held_latch E7: got step=%h latch=%b required 00 11",
                        step_pulse, latch_state);
            end
         end
      end
      keys = '0;
      idle(10);
      checks++;
      if (key_down !== 10'h000 || latch_state !== 2'b11) begin
         errors++;
         $display("FAIL release_all: got kd=%h latch=%b required 000 11", key_down, latch_state);
      end
      clear_latch = 1'b1;
      tick();
      clear_latch = 1'b0;
      checks++;
      if (latch_state !== 2'b00) begin
         errors++;
         $display("FAIL clear_latch: got %b required 00", latch_state);
      end
   endtask

   task automatic test_clean_press();
      keys[5] = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         tick();
         checks++;
         if (step_pulse !== ((c == 6) ? 8'b0000_1000 : 8'h00)) begin
            errors++;
            $display("FAIL clean_press E%0d: got %h required %h", c, step_pulse,
                     (c == 6) ? 8'b0000_1000 : 8'h00);
         end
      end
      for (int c = 0; c < 50; c++) begin
         tick();
         checks++;
         if (step_pulse !== 8'h00 || key_down[5] !== 1'b1) begin
            errors++;
            $display("FAIL held_no_repeat cyc%0d: got step=%h kd5=%b required 00 1",
                     c, step_pulse, key_down[5]);
         end
      end
      keys[5] = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         tick();
         checks++;
         if (step_pulse !== 8'h00) begin
            errors++;
            $display("FAIL release_no_pulse E%0d: got %h required 00", c, step_pulse);
         end
      end
      checks++;
      if (key_down[5] !== 1'b0) begin
         errors++;
         $display("FAIL release_level: got %b required 0", key_down[5]);
      end
   endtask

   task automatic test_reset_mid_debounce();
      keys[4] = 1'b1;
      idle(4);
      n_rst = 1'b0;
      #1;
      checks++;
      if (key_down !== 10'h000 || step_pulse !== 8'h00) begin
         errors++;
         $display("FAIL mid_reset_clear: got kd=%h step=%h required 000 00", key_down, step_pulse);
      end
      tick();
      n_rst = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         tick();
         checks++;
         if (step_pulse !== ((c == 6) ? 8'h04 : 8'h00)) begin
            errors++;
            $display("FAIL mid_reset_requal E%0d: got %h required %h", c, step_pulse,
                     (c == 6) ? 8'h04 : 8'h00);
         end
      end
      keys[4] = 1'b0;
      idle(10);
   endtask

   task automatic test_bounce();
      for (int c = 1; c <= 12; c++) begin
         keys[2] = (c <= 3 || c >= 5);
         tick();
         checks++;
         if (step_pulse !== ((c == 10) ? 8'h01 : 8'h00)) begin
            errors++;
            $display("FAIL bounce E%0d: got %h required %h", c, step_pulse,
                     (c == 10) ? 8'h01 : 8'h00);
         end
      end
      keys[2] = 1'b0;
      idle(10);
   endtask

   task automatic test_en_strobe();
      keys[6] = 1'b1;
      for (int c = 1; c <= 17; c++) begin
         en = (c % 4 == 0);
         tick();
         if (c == 4 || c == 15) begin
            checks++;
            if (key_down[6] !== 1'b0) begin
               errors++;
               $display("FAIL en_strobe_early E%0d: got %b required 0", c, key_down[6]);
            end
         end else if (c == 16) begin
            checks++;
            if (key_down[6] !== 1'b1 || step_pulse !== 8'h10) begin
               errors++;
               $display("FAIL en_strobe_flip E16: got kd6=%b step=%h required 1 10",
                        key_down[6], step_pulse);
            end
         end
      end
      en = 1'b1;
      keys[6] = 1'b0;
      idle(10);
   endtask

   task automatic test_latch();
      for (int p = 0; p < 2; p++) begin
         keys[0] = 1'b1;
         idle(6);
         checks++;
         if (latch_state[0] !== p[0]) begin
            errors++;
            $display("FAIL latch_before_toggle%0d: got %b required %b", p, latch_state[0], p[0]);
         end
         tick();
         checks++;
         if (latch_state[0] !== ~p[0]) begin
            errors++;
            $display("FAIL latch_toggle%0d: got %b required %b", p, latch_state[0], ~p[0]);
         end
         keys[0] = 1'b0;
         idle(10);
      end
      keys[1] = 1'b1;
      idle(6);
      clear_latch = 1'b1;
      tick();
      clear_latch = 1'b0;
      checks++;
      if (latch_state !== 2'b00) begin
         errors++;
         $display("FAIL clear_priority: got %b required 00", latch_state);
      end
      idle(3);
      checks++;
      if (latch_state !== 2'b00) begin
         errors++;
         $display("FAIL clear_hold: got %b required 00", latch_state);
      end
      keys[1] = 1'b0;
      idle(10);
   endtask

   task automatic test_simultaneous();
      keys[9] = 1'b1;
      keys[3] = 1'b1;
      keys[1] = 1'b1;
      keys2[9] = 1'b1;
      keys2[3] = 1'b1;
      keys2[1] = 1'b1;
      idle(5);
      checks++;
      if (step_pulse !== 8'h00 || step_pulse2 !== 16'h0000) begin
         errors++;
         $display("FAIL simul_early: got %h %h required 00 0000", step_pulse, step_pulse2);
      end
      tick();
      checks++;
      if (step_pulse !== 8'b1000_0010 || any_pulse !== 1'b1 || latch_state !== 2'b00) begin
         errors++;
         $display("FAIL simul_pulse: got step=%h any=%b latch=%b required 82 1 00",
                  step_pulse, any_pulse, latch_state);
      end
      checks++;
      if (step_pulse2 !== 16'h0041 || any_pulse2 !== 1'b1 || latch_state2 !== 3'b000) begin
         errors++;
         $display("FAIL simul_pulse_wide: got step=%h any=%b latch=%b required 0041 1 000",
                  step_pulse2, any_pulse2, latch_state2);
      end
      tick();
      checks++;
      if (step_pulse !== 8'h00 || any_pulse !== 1'b0 || latch_state !== 2'b10) begin
         errors++;
         $display("FAIL simul_after: got step=%h any=%b latch=%b required 00 0 10",
                  step_pulse, any_pulse, latch_state);
      end
      checks++;
      if (step_pulse2 !== 16'h0000 || any_pulse2 !== 1'b0 || latch_state2 !== 3'b010) begin
         errors++;
         $display("FAIL simul_after_wide: got step=%h any=%b latch=%b required 0000 0 010",
                  step_pulse2, any_pulse2, latch_state2);
      end
      keys = '0;
      keys2 = '0;
      idle(10);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      keys2 = '0;
      test_reset();
      test_clean_press();
      test_reset_mid_debounce();
      test_bounce();
      test_en_strobe();
      test_latch();
      test_simultaneous();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_key_event_encoder
